// File: rtl/pcm_fifo.sv
// pcm_fifo: CPU-fed 16x24 PCM sample FIFO popped once per I2S frame, with status and low-water irq
module pcm_fifo #(
  parameter int CLK = 3579545,
  parameter int FS  = 96000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [23:0] sound_out,
  output logic        irq
);
  localparam int I2S_DIV = (CLK + 128 * FS - 1) / (128 * FS);
  localparam int SAMPLE_DIV = 128 * I2S_DIV;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0] RELOAD = DW'(SAMPLE_DIV - 1);
  logic [23:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] count, count_next;
  logic [7:0] low_b, mid_b;
  logic enable, irq_en, underflow, overflow;
  logic [DW-1:0] div;
  logic wr, push, ctl, flush, clr, tick, pop, accept, under_set, over_set, en_next, ie_next;
  logic full, empty, low;
  // Decode register writes, the frame tick and the FIFO push/pop decisions
  always_comb begin
    wr = cs & we;
    push = wr & (addr == 2'd2);
    ctl = wr & (addr == 2'd3);
    flush = ctl & din[2];
    clr = ctl & din[1];
    en_next = ctl ? din[0] : enable;
    ie_next = ctl ? din[3] : irq_en;
    tick = enable & (div == '0);
    pop = tick & en_next & ~flush & (count != 5'd0);
    under_set = tick & en_next & ~flush & (count == 5'd0);
    accept = push & ((count != 5'd16) | pop);
    over_set = push & (count == 5'd16) & ~pop;
    count_next = flush ? 5'd0 : count + 5'(accept) - 5'(pop);
    full = count == 5'd16;
    empty = count == 5'd0;
    low = count <= 5'd8;
    dout = addr == 2'd0 ? {3'b0, count} :
           addr == 2'd1 ? {enable, 2'b0, overflow, underflow, low, full, empty} :
           addr == 2'd2 ? sound_out[23:16] : {4'b0, irq_en, 3'b0};
  end
  // Sample storage; the old head is read before a same-cycle write can land
  always_ff @(posedge clk)
    if (accept) mem[wp] <= {din, mid_b, low_b};
  // Control state, pointers, frame divider, output sample and interrupt
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      low_b <= '0;
      mid_b <= '0;
      enable <= 1'b0;
      irq_en <= 1'b0;
      underflow <= 1'b0;
      overflow <= 1'b0;
      div <= RELOAD;
      sound_out <= '0;
      irq <= 1'b0;
    end else begin
      wp <= flush ? 4'd0 : wp + 4'(accept);
      rp <= flush ? 4'd0 : rp + 4'(pop);
      count <= count_next;
      if (wr && addr == 2'd0) low_b <= din;
      if (wr && addr == 2'd1) mid_b <= din;
      enable <= en_next;
      irq_en <= ie_next;
      underflow <= under_set | (underflow & ~clr);
      overflow <= over_set | (overflow & ~clr);
      div <= (!enable || div == '0) ? RELOAD : div - DW'(1);
      sound_out <= !en_next ? 24'd0 : pop ? mem[rp] : sound_out;
      irq <= ie_next & en_next & (count_next <= 5'd8);
    end
endmodule

// File: tb/tb_pcm_fifo.sv
// tb_pcm_fifo: directed register-table and timed-sequence checks for pcm_fifo
module tb_pcm_fifo;
  localparam int SD = 128;
  logic clk = 1'b0, reset = 1'b1, cs = 1'b0, we = 1'b0, irq;
  logic [1:0] addr = '0;
  logic [7:0] din = '0, dout, r;
  logic [23:0] sound_out, hold;
  int total = 0, passed = 0;
  typedef struct {
    logic w;
    logic [1:0] a;
    logic [7:0] d;
    logic [1:0] ra;
    logic [7:0] e;
  } vec_t;
  vec_t v[12];
  pcm_fifo dut (.clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
                .dout(dout), .sound_out(sound_out), .irq(irq));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s got %h want %h", n, a, e);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    cyc(1);
    cs = 1'b0; we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = dout;
  endtask
  task automatic push(input logic [23:0] s);
    wr(2'd0, s[7:0]);
    wr(2'd1, s[15:8]);
    wr(2'd2, s[23:16]);
  endtask
  task automatic rst;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask
  function automatic logic [23:0] smp(input int k);
    return {8'(k + 144), 8'(k + 64), 8'(k)};
  endfunction
  initial begin
    v[0]  = '{1'b0, 2'd0, 8'h00, 2'd0, 8'h00};
    v[1]  = '{1'b0, 2'd0, 8'h00, 2'd1, 8'h05};
    v[2]  = '{1'b0, 2'd0, 8'h00, 2'd3, 8'h00};
    v[3]  = '{1'b1, 2'd3, 8'h08, 2'd3, 8'h08};
    v[4]  = '{1'b1, 2'd0, 8'h11, 2'd0, 8'h00};
    v[5]  = '{1'b1, 2'd1, 8'h22, 2'd1, 8'h05};
    v[6]  = '{1'b1, 2'd2, 8'h33, 2'd0, 8'h01};
    v[7]  = '{1'b0, 2'd0, 8'h00, 2'd1, 8'h04};
    v[8]  = '{1'b1, 2'd3, 8'h0C, 2'd0, 8'h00};
    v[9]  = '{1'b0, 2'd0, 8'h00, 2'd3, 8'h08};
    v[10] = '{1'b1, 2'd3, 8'h02, 2'd1, 8'h05};
    v[11] = '{1'b0, 2'd0, 8'h00, 2'd3, 8'h00};
    cyc(1);
    rst;
    chk("rst_sound", 32'(sound_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 12; i++) begin
      if (v[i].w) wr(v[i].a, v[i].d);
      rd(v[i].ra, r);
      chk($sformatf("vec%0d", i), 32'(r), 32'(v[i].e));
    end
    rst;
    push(24'h123456);
    wr(2'd3, 8'h01);
    cyc(SD - 1);
    chk("first_before_tick", 32'(sound_out), 32'h0);
    cyc(1);
    chk("first_pop", 32'(sound_out), 32'h123456);
    rd(2'd0, r);
    chk("first_count", 32'(r), 32'h0);
    cyc(SD);
    rd(2'd1, r);
    chk("underflow_status", 32'(r), 32'h8D);
    chk("underflow_hold", 32'(sound_out), 32'h123456);
    rst;
    for (int k = 1; k <= 17; k++) push(smp(k));
    rd(2'd0, r);
    chk("full_count", 32'(r), 32'h10);
    rd(2'd1, r);
    chk("full_status", 32'(r), 32'h12);
    wr(2'd3, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      cyc(SD);
      chk($sformatf("order%0d", k), 32'(sound_out), 32'(smp(k)));
    end
    cyc(SD);
    chk("no_sample17", 32'(sound_out), 32'(smp(16)));
    rst;
    for (int k = 1; k <= 16; k++) push(smp(k));
    wr(2'd3, 8'h01);
    wr(2'd0, 8'hCC);
    wr(2'd1, 8'hBB);
    cyc(SD - 3);
    wr(2'd2, 8'hAA);
    rd(2'd0, r);
    chk("pushpop_count", 32'(r), 32'h10);
    rd(2'd1, r);
    chk("pushpop_status", 32'(r), 32'h82);
    chk("pushpop_head", 32'(sound_out), 32'(smp(1)));
    cyc(16 * SD);
    chk("pushpop_tail", 32'(sound_out), 32'hAABBCC);
    rst;
    for (int k = 1; k <= 10; k++) push(smp(k));
    wr(2'd3, 8'h09);
    chk("irq_start", 32'(irq), 32'h0);
    cyc(2 * SD - 1);
    chk("irq_count9", 32'(irq), 32'h0);
    rd(2'd0, r);
    chk("irq_cnt9", 32'(r), 32'h09);
    cyc(1);
    chk("irq_count8", 32'(irq), 32'h1);
    wr(2'd3, 8'h01);
    chk("irq_off", 32'(irq), 32'h0);
    rst;
    for (int k = 1; k <= 5; k++) push(smp(k));
    wr(2'd3, 8'h05);
    rd(2'd0, r);
    chk("flush_count", 32'(r), 32'h0);
    rd(2'd1, r);
    chk("flush_status", 32'(r), 32'h85);
    cyc(SD);
    chk("flush_nopop", 32'(sound_out), 32'h0);
    wr(2'd3, 8'h03);
    push(smp(20));
    push(smp(21));
    cyc(SD - 8);
    wr(2'd3, 8'h05);
    rd(2'd1, r);
    chk("flush_tick_status", 32'(r), 32'h85);
    chk("flush_tick_sound", 32'(sound_out), 32'h0);
    rst;
    for (int k = 1; k <= 4; k++) push(smp(k));
    wr(2'd3, 8'h01);
    cyc(SD);
    chk("dis_pop1", 32'(sound_out), 32'(smp(1)));
    wr(2'd3, 8'h00);
    chk("dis_zero", 32'(sound_out), 32'h0);
    cyc(300);
    hold = sound_out;
    chk("dis_hold", 32'(hold), 32'h0);
    rd(2'd0, r);
    chk("dis_count", 32'(r), 32'h03);
    wr(2'd3, 8'h01);
    cyc(SD);
    chk("reen_pop2", 32'(sound_out), 32'(smp(2)));
    cyc(SD);
    chk("reen_pop3", 32'(sound_out), 32'(smp(3)));
    rd(2'd0, r);
    chk("reen_count", 32'(r), 32'h01);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
